// File: rtl/udma_uart_rx_frame.sv
// UART receive framer: majority-vote sampling, 5..8 data bits,
// optional even parity, 1/2 stop bits, valid/ready holding register.
module udma_uart_rx_frame #(
   parameter int SYNC_STAGES = 2,
   parameter int DIV_WIDTH   = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rx_i,
   input  logic                 cfg_en_i,
   input  logic [DIV_WIDTH-1:0] cfg_div_i,
   input  logic                 cfg_parity_en_i,
   input  logic [1:0]           cfg_bits_i,
   input  logic                 cfg_stop_bits_i,
   output logic [7:0]           rx_data_o,
   output logic                 rx_valid_o,
   input  logic                 rx_ready_i,
   output logic                 busy_o,
   output logic                 char_event_o,
   output logic                 err_parity_o,
   output logic                 err_frame_o,
   output logic                 err_overflow_o
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_rx_d;
   logic [DIV_WIDTH-1:0]   r_cnt;
   logic [DIV_WIDTH-1:0]   r_div;
   logic [1:0]             r_bits;
   logic                   r_par_en;
   logic                   r_stop2;
   logic                   r_s0;
   logic                   r_s1;
   logic [7:0]             r_shift;
   logic [2:0]             r_idx;
   logic                   r_par_acc;
   logic                   r_par_err;
   logic                   r_ferr;
   logic                   r_stop_idx;
   logic [7:0]             r_data;
   logic                   r_valid;
   logic                   r_char_event;
   logic                   r_err_parity;
   logic                   r_err_frame;
   logic                   r_err_ovf;

   logic                   w_rx_s;
   logic [DIV_WIDTH-1:0]   w_div_cfg;
   logic [DIV_WIDTH-1:0]   w_half;
   logic [DIV_WIDTH-1:0]   w_half_m1;
   logic [DIV_WIDTH-1:0]   w_half_p1;
   logic                   w_dec;
   logic                   w_vote;
   logic                   w_start;
   logic                   w_last_bit;
   logic                   w_frame_end;
   logic                   w_ferr;
   logic                   w_load;

   assign w_rx_s    = r_sync[SYNC_STAGES-1];
   assign w_div_cfg = (cfg_div_i < DIV_WIDTH'(3)) ? DIV_WIDTH'(3) : cfg_div_i;
   assign w_half    = r_div >> 1;
   assign w_half_m1 = w_half - DIV_WIDTH'(1);
   assign w_half_p1 = w_half + DIV_WIDTH'(1);
   assign w_dec     = (r_state != ST_IDLE) && (r_cnt == w_half_p1);
   assign w_vote    = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
   assign w_start   = cfg_en_i && r_rx_d && !w_rx_s;
   assign w_last_bit = (r_idx == ({1'b0, r_bits} + 3'd4));
   assign w_frame_end = cfg_en_i && (r_state == ST_STOP) && w_dec &&
                        (!r_stop2 || r_stop_idx);
   assign w_ferr    = r_ferr | ~w_vote;
   assign w_load    = w_frame_end & ~w_ferr & (~r_valid | rx_ready_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync <= '1;
         r_rx_d <= 1'b1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
         r_rx_d <= w_rx_s;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!cfg_en_i) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:   if (w_start) w_state_nxt = ST_START;
            ST_START:  if (w_dec) w_state_nxt = w_vote ? ST_IDLE : ST_DATA;
            ST_DATA:   if (w_dec && w_last_bit)
                          w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_dec) w_state_nxt = ST_STOP;
            ST_STOP:   if (w_frame_end) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Bit timing, vote samples and per-frame accumulators
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt      <= '0;
         r_div      <= DIV_WIDTH'(3);
         r_bits     <= 2'd0;
         r_par_en   <= 1'b0;
         r_stop2    <= 1'b0;
         r_s0       <= 1'b1;
         r_s1       <= 1'b1;
         r_shift    <= 8'h00;
         r_idx      <= 3'd0;
         r_par_acc  <= 1'b0;
         r_par_err  <= 1'b0;
         r_ferr     <= 1'b0;
         r_stop_idx <= 1'b0;
      end else begin
         if (r_state == ST_IDLE)  r_cnt <= '0;
         else if (r_cnt == r_div) r_cnt <= '0;
         else                     r_cnt <= r_cnt + DIV_WIDTH'(1);
         if (r_state == ST_IDLE && w_start) begin
            r_div      <= w_div_cfg;
            r_bits     <= cfg_bits_i;
            r_par_en   <= cfg_parity_en_i;
            r_stop2    <= cfg_stop_bits_i;
            r_shift    <= 8'h00;
            r_idx      <= 3'd0;
            r_par_acc  <= 1'b0;
            r_par_err  <= 1'b0;
            r_ferr     <= 1'b0;
            r_stop_idx <= 1'b0;
         end
         if (r_cnt == w_half_m1) r_s0 <= w_rx_s;
         if (r_cnt == w_half)    r_s1 <= w_rx_s;
         if (w_dec) begin
            case (r_state)
               ST_DATA: begin
                  r_shift[r_idx] <= w_vote;
                  r_par_acc      <= r_par_acc ^ w_vote;
                  r_idx          <= w_last_bit ? 3'd0 : r_idx + 3'd1;
               end
               ST_PARITY: r_par_err <= r_par_acc ^ w_vote;
               ST_STOP: begin
                  if (!w_vote) r_ferr <= 1'b1;
                  r_stop_idx <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_data       <= 8'h00;
         r_valid      <= 1'b0;
         r_char_event <= 1'b0;
         r_err_parity <= 1'b0;
         r_err_frame  <= 1'b0;
         r_err_ovf    <= 1'b0;
      end else begin
         r_char_event <= w_load;
         r_err_parity <= w_frame_end & ~w_ferr & r_par_err;
         r_err_frame  <= w_frame_end & w_ferr;
         r_err_ovf    <= w_frame_end & ~w_ferr & r_valid & ~rx_ready_i;
         if (w_load) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (r_valid && rx_ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rx_data_o      = r_data;
   assign rx_valid_o     = r_valid;
   assign busy_o         = (r_state != ST_IDLE);
   assign char_event_o   = r_char_event;
   assign err_parity_o   = r_err_parity;
   assign err_frame_o    = r_err_frame;
   assign err_overflow_o = r_err_ovf;

endmodule

// File: tb/tb_udma_uart_rx_frame.sv
// Directed bench for udma_uart_rx_frame: framing, parity, overflow,
// glitch rejection, enable drop and reset mid-frame.
module tb_udma_uart_rx_frame;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        rx_i = 1'b1;
   logic        cfg_en_i = 1'b1;
   logic [15:0] cfg_div_i = 16'd9;
   logic        cfg_parity_en_i = 1'b0;
   logic [1:0]  cfg_bits_i = 2'd3;
   logic        cfg_stop_bits_i = 1'b0;
   logic [7:0]  rx_data_o;
   logic        rx_valid_o;
   logic        rx_ready_i = 1'b1;
   logic        busy_o;
   logic        char_event_o;
   logic        err_parity_o;
   logic        err_frame_o;
   logic        err_overflow_o;

   int n_tests = 0;
   int n_fail = 0;
   int n_char = 0, n_par = 0, n_frm = 0, n_ovf = 0, n_long = 0;
   logic p_char = 0, p_par = 0, p_frm = 0, p_ovf = 0;

   udma_uart_rx_frame #(.SYNC_STAGES(2), .DIV_WIDTH(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i),
      .cfg_en_i(cfg_en_i), .cfg_div_i(cfg_div_i),
      .cfg_parity_en_i(cfg_parity_en_i), .cfg_bits_i(cfg_bits_i),
      .cfg_stop_bits_i(cfg_stop_bits_i),
      .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
      .rx_ready_i(rx_ready_i), .busy_o(busy_o),
      .char_event_o(char_event_o), .err_parity_o(err_parity_o),
      .err_frame_o(err_frame_o), .err_overflow_o(err_overflow_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (char_event_o) n_char++;
      if (err_parity_o) n_par++;
      if (err_frame_o) n_frm++;
      if (err_overflow_o) n_ovf++;
      if ((char_event_o && p_char) || (err_parity_o && p_par) ||
          (err_frame_o && p_frm) || (err_overflow_o && p_ovf)) n_long++;
      p_char = char_event_o;
      p_par  = err_parity_o;
      p_frm  = err_frame_o;
      p_ovf  = err_overflow_o;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic send_frame(input logic [7:0] d, input int nb,
                             input bit par, input bit flip,
                             input int nstop, input logic stop_v,
                             input int glitch_bit);
      int p;
      logic pb;
      p = ((cfg_div_i < 3) ? 3 : int'(cfg_div_i)) + 1;
      pb = flip;
      rx_i = 1'b0;
      idle(p);
      for (int i = 0; i < nb; i++) begin
         rx_i = d[i];
         pb = pb ^ d[i];
         if (glitch_bit == i) begin
            idle(6);
            rx_i = ~d[i];
            idle(1);
            rx_i = d[i];
            idle(p - 7);
         end else begin
            idle(p);
         end
      end
      if (par) begin
         rx_i = pb;
         idle(p);
      end
      for (int s = 0; s < nstop; s++) begin
         rx_i = stop_v;
         idle(p);
      end
   endtask

   task automatic test_reset();
      idle(3);
      n_tests++;
      if ({rx_data_o, rx_valid_o, busy_o, char_event_o, err_parity_o,
           err_frame_o, err_overflow_o} !== 14'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got data=%h v=%b busy=%b want all 0",
                  rx_data_o, rx_valid_o, busy_o);
      end
      rst_i = 1'b0;
      idle(5);
      n_tests++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_busy: got %b want 0", busy_o);
      end
   endtask

   task automatic test_basic_8n1();
      int lat, c0;
      logic [7:0] got;
      lat = 0;
      got = 8'hxx;
      c0 = n_char;
      cfg_div_i = 16'd9; cfg_bits_i = 2'd3;
      cfg_parity_en_i = 1'b0; cfg_stop_bits_i = 1'b0;
      rx_ready_i = 1'b1;
      fork
         send_frame(8'hA5, 8, 0, 0, 1, 1'b1, -1);
         begin
            while (!rx_valid_o && lat < 300) begin
               @(negedge clk_i);
               lat++;
            end
            got = rx_data_o;
         end
      join
      idle(10);
      n_tests++;
      if (lat < 97 || lat > 100) begin
         n_fail++;
         $display("FAIL t1_latency: got %0d cycles want 97..100", lat);
      end
      n_tests++;
      if (got !== 8'hA5) begin
         n_fail++;
         $display("FAIL t1_data: got %h want a5", got);
      end
      n_tests++;
      if (n_char - c0 !== 1) begin
         n_fail++;
         $display("FAIL t1_char_event: got %0d want 1", n_char - c0);
      end
   endtask

   task automatic test_parity();
      int c0, p0;
      cfg_bits_i = 2'd0; cfg_parity_en_i = 1'b1; cfg_stop_bits_i = 1'b1;
      c0 = n_char; p0 = n_par;
      send_frame(8'h13, 5, 1, 0, 2, 1'b1, -1);
      idle(10);
      n_tests++;
      if (rx_data_o !== 8'h13 || n_par - p0 !== 0) begin
         n_fail++;
         $display("FAIL t2_good: got data=%h perr=%0d want 13/0",
                  rx_data_o, n_par - p0);
      end
      send_frame(8'h13, 5, 1, 1, 2, 1'b1, -1);
      idle(10);
      n_tests++;
      if (rx_data_o !== 8'h13 || n_par - p0 !== 1) begin
         n_fail++;
         $display("FAIL t2_bad: got data=%h perr=%0d want 13/1",
                  rx_data_o, n_par - p0);
      end
      n_tests++;
      if (n_char - c0 !== 2) begin
         n_fail++;
         $display("FAIL t2_chars: got %0d want 2", n_char - c0);
      end
   endtask

   task automatic test_overflow();
      int c0, o0;
      cfg_bits_i = 2'd3; cfg_parity_en_i = 1'b0; cfg_stop_bits_i = 1'b0;
      rx_ready_i = 1'b0;
      c0 = n_char; o0 = n_ovf;
      send_frame(8'h11, 8, 0, 0, 1, 1'b1, -1);
      idle(5);
      send_frame(8'h22, 8, 0, 0, 1, 1'b1, -1);
      idle(5);
      n_tests++;
      if (rx_data_o !== 8'h11 || rx_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL t3_hold: got data=%h v=%b want 11/1",
                  rx_data_o, rx_valid_o);
      end
      n_tests++;
      if (n_ovf - o0 !== 1 || n_char - c0 !== 1) begin
         n_fail++;
         $display("FAIL t3_counts: got ovf=%0d chr=%0d want 1/1",
                  n_ovf - o0, n_char - c0);
      end
      rx_ready_i = 1'b1;
      @(negedge clk_i);
      n_tests++;
      if (rx_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL t3_consume: got v=%b want 0", rx_valid_o);
      end
   endtask

   task automatic test_glitch();
      int c0, e0;
      cfg_div_i = 16'd15;
      c0 = n_char; e0 = n_par + n_frm + n_ovf;
      rx_i = 1'b0;
      idle(3);
      rx_i = 1'b1;
      idle(40);
      n_tests++;
      if (busy_o !== 1'b0 || n_char - c0 !== 0 ||
          n_par + n_frm + n_ovf - e0 !== 0) begin
         n_fail++;
         $display("FAIL t4_false_start: got busy=%b chr=%0d err=%0d want 0",
                  busy_o, n_char - c0, n_par + n_frm + n_ovf - e0);
      end
      send_frame(8'h96, 8, 0, 0, 1, 1'b1, 3);
      idle(10);
      n_tests++;
      if (rx_data_o !== 8'h96 || n_char - c0 !== 1) begin
         n_fail++;
         $display("FAIL t4_glitch_data: got %h chr=%0d want 96/1",
                  rx_data_o, n_char - c0);
      end
      cfg_div_i = 16'd9;
   endtask

   task automatic test_frame_error();
      int c0, f0;
      c0 = n_char; f0 = n_frm;
      send_frame(8'h55, 8, 0, 0, 1, 1'b0, -1);
      idle(40);
      n_tests++;
      if (n_frm - f0 !== 1 || n_char - c0 !== 0) begin
         n_fail++;
         $display("FAIL t5_counts: got frm=%0d chr=%0d want 1/0",
                  n_frm - f0, n_char - c0);
      end
      n_tests++;
      if (rx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL t5_low_line: got v=%b busy=%b want 0/0",
                  rx_valid_o, busy_o);
      end
      rx_i = 1'b1;
      idle(20);
      n_tests++;
      if (busy_o !== 1'b0 || n_frm - f0 !== 1) begin
         n_fail++;
         $display("FAIL t5_release: got busy=%b frm=%0d want 0/1",
                  busy_o, n_frm - f0);
      end
   endtask

   task automatic test_enable_reset();
      int c0, e0;
      logic b_before, b_after;
      b_before = 1'b0;
      b_after = 1'b1;
      c0 = n_char; e0 = n_par + n_frm + n_ovf;
      fork
         send_frame(8'h3C, 8, 0, 0, 1, 1'b1, -1);
         begin
            idle(45);
            b_before = busy_o;
            cfg_en_i = 1'b0;
            @(negedge clk_i);
            b_after = busy_o;
         end
      join
      idle(20);
      cfg_en_i = 1'b1;
      idle(5);
      n_tests++;
      if (b_before !== 1'b1 || b_after !== 1'b0) begin
         n_fail++;
         $display("FAIL t6_en_busy: got %b->%b want 1->0", b_before, b_after);
      end
      n_tests++;
      if (n_char - c0 !== 0 || n_par + n_frm + n_ovf - e0 !== 0 ||
          rx_valid_o !== 1'b0 || rx_data_o !== 8'h96) begin
         n_fail++;
         $display("FAIL t6_en_output: got chr=%0d err=%0d v=%b d=%h",
                  n_char - c0, n_par + n_frm + n_ovf - e0,
                  rx_valid_o, rx_data_o);
      end
      rx_ready_i = 1'b0;
      send_frame(8'h77, 8, 0, 0, 1, 1'b1, -1);
      idle(5);
      n_tests++;
      if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h77) begin
         n_fail++;
         $display("FAIL t6_preload: got v=%b d=%h want 1/77",
                  rx_valid_o, rx_data_o);
      end
      fork
         send_frame(8'h3C, 8, 0, 0, 1, 1'b1, -1);
         begin
            idle(25);
            rst_i = 1'b1;
            #1;
            n_tests++;
            if ({rx_data_o, rx_valid_o, busy_o, char_event_o, err_parity_o,
                 err_frame_o, err_overflow_o} !== 14'd0) begin
               n_fail++;
               $display("FAIL t6_rst_mid: got d=%h v=%b busy=%b want 0",
                        rx_data_o, rx_valid_o, busy_o);
            end
         end
      join
      idle(2);
      rst_i = 1'b0;
      rx_ready_i = 1'b1;
      idle(5);
      c0 = n_char;
      send_frame(8'h3C, 8, 0, 0, 1, 1'b1, -1);
      idle(10);
      n_tests++;
      if (rx_data_o !== 8'h3C || n_char - c0 !== 1) begin
         n_fail++;
         $display("FAIL t6_after_rst: got d=%h chr=%0d want 3c/1",
                  rx_data_o, n_char - c0);
      end
   endtask

   task automatic test_back_to_back();
      int c0;
      c0 = n_char;
      send_frame(8'h5A, 8, 0, 0, 1, 1'b1, -1);
      send_frame(8'hC3, 8, 0, 0, 1, 1'b1, -1);
      idle(10);
      n_tests++;
      if (rx_data_o !== 8'hC3 || n_char - c0 !== 2) begin
         n_fail++;
         $display("FAIL b2b: got d=%h chr=%0d want c3/2",
                  rx_data_o, n_char - c0);
      end
      n_tests++;
      if (n_long !== 0) begin
         n_fail++;
         $display("FAIL pulse_width: got %0d long pulses want 0", n_long);
      end
   endtask

   initial begin
      test_reset();
      test_basic_8n1();
      test_parity();
      test_overflow();
      test_glitch();
      test_frame_error();
      test_enable_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
